// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated mux.
//   arb_state_t : grant state (IDLE = free arbitration, LOCKED = packet in flight)
//   next_idx    : (idx + 1) mod n without a divider
package arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Cyclic increment; callers always pass idx < n
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Stream bundle between N producers, the arbitrated mux and one consumer.
//   in_valid/in_ready/in_data/in_last : N producer channels, channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data/out_last/out_sel : merged consumer stream
//   slave  : the mux side
//   master : the environment side (producers and consumer)
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SEL_W-1:0]   out_sel;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, searched cyclically.
//   req       : per-channel request
//   ptr       : highest-priority channel this cycle (always < N)
//   grant     : one-hot grant
//   grant_idx : encoded grant (0 when nothing requests)
//   any_req   : at least one request present
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [$clog2(N)-1:0]   ptr,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   grant_idx,
  output logic                   any_req
);

  localparam int unsigned SEL_W = $clog2(N);

  int unsigned idx;

  // Walk offsets 0..N-1 from ptr; the wrap is a subtraction so non-power-of-2 N never exceeds N-1
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[SEL_W'(idx)]) begin
        any_req               = 1'b1;
        grant_idx             = SEL_W'(idx);
        grant[SEL_W'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with a registered output beat.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : stream bundle (slave side); in_ready is combinational, all out_* are registered
// With PACKET_MODE=1 the grant stays with its owner until that channel's in_last beat.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned N           = 4,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  rr_arb_mux_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(N);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] owner;

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_req;

  logic             load;
  logic             xfer;
  logic [N-1:0]     rdy;
  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] win_data;
  logic             win_last;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Output register can take a beat when empty or being drained this cycle
  assign load = !bus.out_valid || bus.out_ready;

  // Ready goes only to the current winner; a locked owner keeps ready even without valid
  always_comb begin
    rdy = '0;
    win = grant_idx;
    if (state == LOCKED) begin
      win        = owner;
      rdy[owner] = load;
    end else if (any_req) begin
      rdy = grant & {N{load}};
    end
    if (reset) rdy = '0;
  end

  assign bus.in_ready = rdy;
  assign xfer         = |(bus.in_valid & rdy);

  // Winner's payload
  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win == SEL_W'(i)) begin
        win_data = bus.in_data[i*WIDTH +: WIDTH];
        win_last = bus.in_last[i];
      end
    end
  end

  // Grant state, pointer and output beat register
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sel   <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= win_data;
      bus.out_last  <= win_last;
      bus.out_sel   <= win;
      if (PACKET_MODE != 0 && !win_last) begin
        // Mid-packet: hold the grant, ptr stays so fairness resumes after the packet
        state <= LOCKED;
        owner <= win;
      end else begin
        state <= IDLE;
        ptr   <= SEL_W'(next_idx(32'(win), N));
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Unit 0: N=4, WIDTH=8, per-beat arbitration.  Unit 1: N=3, WIDTH=12, packet mode.
  rr_arb_mux_if #(.WIDTH(8),  .N(4)) bus_a ();
  rr_arb_mux_if #(.WIDTH(12), .N(3)) bus_b ();

  rr_arb_mux #(.WIDTH(8),  .N(4), .PACKET_MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  rr_arb_mux #(.WIDTH(12), .N(3), .PACKET_MODE(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus per unit
  logic [3:0]  s_valid  [2];
  logic [3:0]  s_last   [2];
  logic [11:0] s_data   [2][4];
  logic        s_oready [2];

  // Reference model per unit
  int          m_ptr    [2];
  int          m_owner  [2];
  bit          m_locked [2];
  bit          m_ov     [2];
  logic [11:0] m_od     [2];
  bit          m_ol     [2];
  int          m_os     [2];

  function automatic int chn(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic bit pmode(input int u);
    return u != 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    bus_a.in_valid  = s_valid[0];
    bus_a.in_last   = s_last[0];
    bus_a.out_ready = s_oready[0];
    for (int i = 0; i < 4; i++) bus_a.in_data[i*8 +: 8] = s_data[0][i][7:0];
    bus_b.in_valid  = s_valid[1][2:0];
    bus_b.in_last   = s_last[1][2:0];
    bus_b.out_ready = s_oready[1];
    for (int i = 0; i < 3; i++) bus_b.in_data[i*12 +: 12] = s_data[1][i];
  endtask

  task automatic idle_all();
    for (int u = 0; u < 2; u++) begin
      s_valid[u]  = '0;
      s_last[u]   = '0;
      s_oready[u] = 1'b1;
      for (int i = 0; i < 4; i++) s_data[u][i] = '0;
    end
  endtask

  // Expected ready mask and winner from the arbitration rules
  task automatic model_eval(input int u, output logic [3:0] exp_rdy, output int win, output bit xfer);
    int n;
    bit load;
    n       = chn(u);
    load    = !m_ov[u] || s_oready[u];
    exp_rdy = '0;
    win     = -1;
    xfer    = 1'b0;
    if (reset) return;
    if (m_locked[u]) win = m_owner[u];
    else begin
      for (int k = 0; k < n; k++)
        if (win < 0 && s_valid[u][2'((m_ptr[u] + k) % n)]) win = (m_ptr[u] + k) % n;
    end
    if (win >= 0 && load) begin
      exp_rdy[2'(win)] = 1'b1;
      xfer = s_valid[u][2'(win)];
    end
  endtask

  task automatic model_update(input int u, input int win, input bit xfer);
    if (reset) begin
      m_ptr[u] = 0; m_owner[u] = 0; m_locked[u] = 0;
      m_ov[u] = 0; m_od[u] = '0; m_ol[u] = 0; m_os[u] = 0;
      return;
    end
    if (xfer) begin
      m_ov[u] = 1;
      m_od[u] = s_data[u][2'(win)];
      m_ol[u] = s_last[u][2'(win)];
      m_os[u] = win;
      if (pmode(u) && !s_last[u][2'(win)]) begin
        m_locked[u] = 1;
        m_owner[u]  = win;
      end else begin
        m_locked[u] = 0;
        m_ptr[u]    = (win + 1) % chn(u);
      end
    end else if (s_oready[u]) begin
      m_ov[u] = 0;
    end
  endtask

  // One clock: drive at edge+1, check ready mid-cycle, check outputs at next edge+1
  task automatic step();
    logic [3:0] er [2];
    int         w  [2];
    bit         x  [2];
    logic [31:0] ov, od, ol, os, rd;
    apply();
    #4;
    for (int u = 0; u < 2; u++) begin
      model_eval(u, er[u], w[u], x[u]);
      rd = (u == 0) ? 32'(bus_a.in_ready) : 32'(bus_b.in_ready);
      check(u == 0 ? "a_in_ready" : "b_in_ready", rd, 32'(er[u]));
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      model_update(u, w[u], x[u]);
      ov = (u == 0) ? 32'(bus_a.out_valid) : 32'(bus_b.out_valid);
      od = (u == 0) ? 32'(bus_a.out_data)  : 32'(bus_b.out_data);
      ol = (u == 0) ? 32'(bus_a.out_last)  : 32'(bus_b.out_last);
      os = (u == 0) ? 32'(bus_a.out_sel)   : 32'(bus_b.out_sel);
      check(u == 0 ? "a_out_valid" : "b_out_valid", ov, 32'(m_ov[u]));
      if (m_ov[u]) begin
        check(u == 0 ? "a_out_data" : "b_out_data", od, 32'(m_od[u]));
        check(u == 0 ? "a_out_last" : "b_out_last", ol, 32'(m_ol[u]));
        check(u == 0 ? "a_out_sel"  : "b_out_sel",  os, 32'(m_os[u]));
      end
    end
  endtask

  logic [7:0]  held;
  logic [11:0] pk_data [4];
  logic        pk_last [4];

  initial begin
    idle_all();
    // Reset with every channel requesting
    reset = 1'b1;
    s_valid[0] = 4'hF;
    s_valid[1] = 4'h7;
    step();
    check("rst_ready_a", 32'(bus_a.in_ready), 32'h0);
    step();
    check("rst_ready_b", 32'(bus_b.in_ready), 32'h0);
    reset = 1'b0;
    check("rst_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst_data",  32'(bus_a.out_data),  32'h0);
    check("rst_sel",   32'(bus_a.out_sel),   32'h0);
    check("rst_last",  32'(bus_b.out_last),  32'h0);

    // Fairness: all channels valid, consumer always ready
    idle_all();
    s_valid[0] = 4'hF;
    for (int i = 0; i < 4; i++) s_data[0][i] = 12'(8'hA0 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      check("fair_data", 32'(bus_a.out_data), 32'(8'hA0 + (k % 4)));
      check("fair_sel",  32'(bus_a.out_sel),  32'(k % 4));
    end

    // Backpressure: beat held, no ready, then next winner without a gap
    held = bus_a.out_data;
    s_oready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold", 32'(bus_a.out_data), 32'(held));
      check("bp_ready", 32'(bus_a.in_ready), 32'h0);
    end
    s_oready[0] = 1'b1;
    step();
    check("bp_resume", 32'(bus_a.out_data), 32'(8'hA1));
    check("bp_valid",  32'(bus_a.out_valid), 32'h1);

    // Packet lock on unit 1: ch1 11,12,13(last) while ch2 holds 22(last)
    idle_all();
    pk_data[0] = 12'h011; pk_last[0] = 1'b0;
    pk_data[1] = 12'h012; pk_last[1] = 1'b0;
    pk_data[2] = 12'h013; pk_last[2] = 1'b1;
    pk_data[3] = 12'h022; pk_last[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid[1]   = (k < 3) ? 4'b0110 : 4'b0100;
      s_data[1][1] = pk_data[k < 3 ? k : 2];
      s_last[1][1] = pk_last[k < 3 ? k : 2];
      s_data[1][2] = 12'h022;
      s_last[1][2] = 1'b1;
      step();
      check("pkt_data", 32'(bus_b.out_data), 32'(pk_data[k]));
      check("pkt_last", 32'(bus_b.out_last), 32'(pk_last[k]));
    end

    // Width/count override: ch2 alone, then ch0 beats ch1 after the wrap
    idle_all();
    s_valid[1] = 4'b0100; s_data[1][2] = 12'hABC; s_last[1][2] = 1'b1;
    step();
    check("w12_data", 32'(bus_b.out_data), 32'h0ABC);
    check("w12_sel",  32'(bus_b.out_sel),  32'h2);
    idle_all();
    s_valid[1] = 4'b0011; s_last[1] = 4'b0011;
    s_data[1][0] = 12'h100; s_data[1][1] = 12'h101;
    step();
    check("wrap_sel", 32'(bus_b.out_sel), 32'h0);

    // Reset mid-packet: lock on ch1 must be discarded
    idle_all();
    s_valid[1] = 4'b0010; s_data[1][1] = 12'h031; s_last[1][1] = 1'b0;
    step();
    check("mid_first", 32'(bus_b.out_data), 32'h031);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_valid", 32'(bus_b.out_valid), 32'h0);
    s_valid[1] = 4'b0011; s_last[1] = 4'b0011;
    s_data[1][0] = 12'h0C0; s_data[1][1] = 12'h0C1;
    step();
    check("mid_win_sel",  32'(bus_b.out_sel),  32'h0);
    check("mid_win_data", 32'(bus_b.out_data), 32'h0C0);

    // Randomised traffic on both units
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 2; u++) begin
        s_valid[u]  = 4'($urandom);
        s_last[u]   = 4'($urandom) & 4'($urandom);
        s_oready[u] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++)
          s_data[u][i] = (u == 0) ? 12'($urandom_range(0, 255)) : 12'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parameterised N-channel, WIDTH-bit multiplexer with a round-robin arbiter, valid/ready handshakes and a registered output stage.
- Successor to the combinational 2:1 and 4:1 muxes: channel selection is made by the block itself, not by an external select.
- Optional packet mode locks the grant until the owning channel's last beat.
- Merges several producer streams into one consumer stream in datapath and bus fabric.

Parameters:
- WIDTH, 8, data width in bits (≥1).
- N, 4, number of input channels (≥2).
- PACKET_MODE, 0, 0 = arbitrate every beat; 1 = hold grant until in_last.
- SEL_W, $clog2(N), width of out_sel; derived, never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  N  per-channel end-of-packet flag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  WIDTH  registered beat.
- out_last  out  1  registered copy of the winning in_last.
- out_sel  out  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
  - While reset=1: in_ready=0.
  - After the edge: out_valid=0, out_data=0, out_last=0, out_sel=0, pointer ptr=0, state IDLE.
- Handshakes:
  - Transfer occurs on any edge where valid&ready are both high.
  - load = !out_valid || out_ready.
  - in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- State IDLE:
  - Winner = first channel with in_valid=1, searching ptr, ptr+1, … cyclically mod N.
  - in_ready[winner]=load; all other in_ready=0. No valid input → in_ready all 0.
- Transfer in IDLE:
  - Register in_data/in_last of winner into out_data/out_last; out_sel=winner; out_valid=1.
  - If PACKET_MODE=1 and in_last=0: go to LOCKED, owner=winner, ptr unchanged.
  - Otherwise: ptr=(winner+1) mod N.
- State LOCKED:
  - Only owner considered: in_ready[owner]=load, others 0, even if owner in_valid=0.
  - Transfer with in_last=1 → IDLE, ptr=(owner+1) mod N.
- Output stage:
  - out_valid=1 with out_ready=0: out_data/out_last/out_sel held stable, all in_ready=0.
  - out_ready=1 with no new transfer: out_valid→0.
  - out_ready=1 with a new transfer in the same cycle: replace the beat. Sustained throughput is 1 beat/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- PACKET_MODE=0: in_last passes through to out_last; never locks.
- Wrap-around: ptr from N-1 goes to 0; non-power-of-2 N must never select an index ≥N.
- Reset mid-packet: lock and registered beat discarded; state returns to the reset values.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - a function next_idx(idx, n) returning (idx+1) mod n.
- One sub-module, rr_arbiter:
  - Combinational; parameter N.
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant[N], encoded grant_idx, any_req.
- rr_arb_mux owns the state, ptr and output register.

Test Plan:
- Reset: reset=1 for 2 cycles with all in_valid=1 → in_ready=0000 during reset; afterwards out_valid=0, out_data=0, out_sel=0.
- Fairness (N=4, WIDTH=8, PACKET_MODE=0): all valid, ch i data=8'hA0+i held, out_ready=1 → from cycle 1 out_data A0,A1,A2,A3,A0 each cycle; out_sel 0,1,2,3,0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → out_data constant, in_ready=0000; out_ready=1 → next winner's beat appears the following cycle with no gap or loss.
- Packet lock (PACKET_MODE=1):
  - Stimulus: ch1 beats 8'h11, 8'h12, 8'h13 (in_last on 13); ch2 valid with 8'h22 throughout.
  - Response: out 11,12,13,22 with no interleave; out_last=1 on 13 and 22.
- Width/count override (WIDTH=12, N=3): only ch2 valid with 12'hABC → out_data=12'hABC, out_sel=2 one cycle later; ptr wraps to 0 (verify next request ch0 wins over ch1).
- Reset mid-packet: reset after ch1 beat 1 of 3 → afterwards state IDLE, out_valid=0; ch0 and ch1 both valid → ch0 wins (ptr=0).
